bm_sad_rdctl: RTL
=================

Name: bm_sad_rdctl

Overview:
Read-side controller that sits directly downstream of the block-matching SAD line buffer.
- Waits for the buffer's rd_rdy, which indicates that a complete line is stored.
- Sweeps the line-relative read address from 0 to line_size-1 and absorbs the buffer's 1-cycle RAM read latency.
- Streams the 64-bit words (8 pixels each) to the SAD datapath over a valid/ready handshake with a 2-entry skid FIFO.
- Pulses next_line once the last word of the line has been accepted, which releases that line in the buffer.

Parameters:
ADDR_W, 10, width of the line-relative read address and of line_size
DATA_W, 64, width of a buffer word and of out_data
CNT_W, 16, width of the line_cnt counter

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
enb  in  1  global enable; the same signal drives the buffer RAM enable
start  in  1  frame start; synchronous clear
line_size  in  ADDR_W  line length in 64-bit words; sampled on the IDLE->READ transition
rd_rdy  in  1  buffer holds at least one complete line
sad_rdaddr  out  ADDR_W  line-relative read address to the buffer
sad_dout  in  DATA_W  buffer read data, valid 1 cycle after the address
next_line  out  1  1-cycle pulse that releases the current line in the buffer
out_valid  out  1  output word valid
out_ready  in  1  downstream accepts the word
out_data  out  DATA_W  output word
out_last  out  1  marks the final word of a line
busy  out  1  FSM is not in IDLE
line_cnt  out  CNT_W  number of lines released since start

Behaviour:
- Reset values: sad_rdaddr=0, next_line=0, out_valid=0, out_data=0, out_last=0, busy=0, line_cnt=0, FSM=IDLE, FIFO empty, in-flight flag=0.
- start has priority over every other input:
  - FSM goes to IDLE, the FIFO is flushed, and the in-flight flag is cleared.
  - sad_rdaddr and line_cnt are cleared.
  - No next_line pulse is generated.
- enb=0 freezes the FSM, the address counter and read issue. The capture of an already in-flight word and the output handshake are not gated by enb.
- FSM states and transitions:
  - IDLE: when enb & rd_rdy, latch len=line_size and clear sad_rdaddr.
    - len != 0 -> READ.
    - len == 0 -> RELEASE (no reads are issued).
  - READ: a read is issued in any cycle where issue = enb & (fifo_cnt + inflight - pop) < 2, with pop = out_valid & out_ready.
    - Each issue sets inflight for the next cycle, tags that word last = (sad_rdaddr == len-1), and increments sad_rdaddr.
    - The issue of the last word -> DRAIN.
  - DRAIN: wait for pop & out_last -> RELEASE.
  - RELEASE: next_line=1 for exactly 1 cycle, line_cnt += 1 (wraps at 2^CNT_W) -> IDLE.
- Data capture:
  - When inflight=1, sad_dout and its last tag are pushed into the FIFO at the end of that cycle.
  - The push and a pop may occur in the same cycle. The issue rule guarantees the FIFO never overflows.
- Output:
  - out_valid = FIFO non-empty.
  - out_data and out_last come from the FIFO head.
  - out_data and out_last hold stable while out_valid & ~out_ready.
- Latency: rd_rdy sampled in IDLE at cycle 0 -> address 0 issued at cycle 1 -> sad_dout captured at cycle 2 -> out_valid=1 at cycle 3.
- Throughput: 1 word/cycle sustained while out_ready=1.
- Ordering constraint: next_line is never asserted while any read of the current line is outstanding, because the buffer's line offset changes when next_line pops its status FIFO.
- Back-to-back lines: when rd_rdy is still 1 on return to IDLE, the next line starts 1 cycle later (IDLE occupies 1 cycle).
- sad_rdaddr counts only from 0 to len-1. The wrap of the absolute address inside the buffer is not this block's concern.
- Reset asserted mid-line: all state returns to the reset values immediately.

Test Plan:
- line_size=4, rd_rdy=1, out_ready=1: sad_rdaddr issues 0,1,2,3 on cycles 1-4; out_valid on cycles 3-6 with out_last only on cycle 6; next_line pulses on cycle 7; line_cnt=1.
- line_size=8, out_ready toggles 1/0 every cycle: all 8 words delivered in order, none duplicated or dropped; FIFO count never exceeds 2; data stable while stalled; exactly 1 next_line pulse.
- rd_rdy held high for 3 lines with line_size=5, out_ready=1: 15 words, out_last on words 5, 10 and 15; 3 next_line pulses each following the corresponding last word; line_cnt=3.
- line_size=0 with rd_rdy=1: no reads issued, out_valid stays 0, next_line pulses once, line_cnt=1.
- start asserted on cycle 3 of a 6-word line: out_valid=0 on the next cycle, FSM is IDLE, line_cnt=0, no next_line pulse.
- enb=0 for 4 cycles mid-line with line_size=6: issue pauses and sad_rdaddr holds; the in-flight word is still delivered; the line completes with 6 words and 1 next_line pulse.

Source files
------------

// File: rtl/bm_sad_rdctl.sv
// Read-side controller for the block-matching SAD line buffer: sweeps one line,
// absorbs the 1-cycle RAM latency and streams words through a 2-entry skid FIFO.
module bm_sad_rdctl #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 64,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enb,
  input  logic              start,
  input  logic [ADDR_W-1:0] line_size,
  input  logic              rd_rdy,
  output logic [ADDR_W-1:0] sad_rdaddr,
  input  logic [DATA_W-1:0] sad_dout,
  output logic              next_line,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic [CNT_W-1:0]  line_cnt
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_REL   = 2'd3;

  logic [1:0]        state;
  logic [ADDR_W-1:0] len;
  logic              vld_p1;
  logic              last_p1;
  logic [DATA_W-1:0] fifo_data [2];
  logic [1:0]        fifo_last;
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        fifo_cnt;
  logic [2:0]        occ;
  logic              pop;
  logic              push;
  logic              issue;
  logic              addr_last;
  logic              take_line;
  logic              drained;

  assign out_valid = (fifo_cnt != 2'd0);
  assign pop       = out_valid & out_ready;
  assign push      = vld_p1;
  // Count the word still in the RAM pipe so the FIFO can never overflow.
  assign occ       = {1'b0, fifo_cnt} + {2'b0, vld_p1} - {2'b0, pop};
  assign issue     = enb & (state == S_READ) & (occ < 3'd2);
  assign addr_last = (sad_rdaddr == len - ADDR_W'(1));
  assign take_line = enb & ~start & (state == S_IDLE) & rd_rdy;
  // Also true if the last word left while enb was low, so DRAIN cannot lock up.
  assign drained   = (pop & out_last) | ((fifo_cnt == 2'd0) & ~vld_p1);

  assign out_data  = out_valid ? fifo_data[rd_ptr] : '0;
  assign out_last  = out_valid & fifo_last[rd_ptr];
  assign busy      = (state != S_IDLE);
  assign next_line = (state == S_REL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      sad_rdaddr <= '0;
      line_cnt   <= '0;
      vld_p1     <= 1'b0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      fifo_cnt   <= 2'd0;
    end else if (start) begin
      state      <= S_IDLE;
      sad_rdaddr <= '0;
      line_cnt   <= '0;
      vld_p1     <= 1'b0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      fifo_cnt   <= 2'd0;
    end else begin
      // p0 -> p1: address issued this cycle, RAM data appears next cycle
      vld_p1   <= issue;
      // p1 -> FIFO: capture is independent of enb
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      fifo_cnt <= fifo_cnt + {1'b0, push} - {1'b0, pop};
      if (enb) begin
        case (state)
          S_IDLE: begin
            if (rd_rdy) begin
              sad_rdaddr <= '0;
              state      <= (line_size != '0) ? S_READ : S_REL;
            end
          end
          S_READ: begin
            if (issue) begin
              sad_rdaddr <= sad_rdaddr + ADDR_W'(1);
              if (addr_last) state <= S_DRAIN;
            end
          end
          S_DRAIN: begin
            if (drained) state <= S_REL;
          end
          default: begin
            line_cnt <= line_cnt + CNT_W'(1);
            state    <= S_IDLE;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (take_line) len <= line_size;
    if (issue) last_p1 <= addr_last;
    if (push) begin
      fifo_data[wr_ptr] <= sad_dout;
      fifo_last[wr_ptr] <= last_p1;
    end
  end

endmodule
